// File: rtl/score_pkg.sv
// ============================================================================
// score_pkg
// Shared constants for the binary-to-packed-BCD score converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package score_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Largest value representable in the given number of BCD digits.
  function automatic int bcd_max(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// bcd_add3
// Single-digit double-dabble corrector: digits 5..9 get +3 before the shift.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

`default_nettype wire

// File: rtl/score_bin2bcd.sv
// ============================================================================
// score_bin2bcd
// Sequential shift-add-3 converter feeding the 7-segment display multiplexer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_bin2bcd #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy,
  output logic                  ovf
);

  import score_pkg::*;

  localparam int ACC_W   = 4 * DIGITS;
  localparam int CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int CMP_W   = (BIN_W > 32) ? BIN_W + 1 : 33;
  localparam int MAX_VAL = bcd_max(DIGITS);

  localparam logic [CMP_W-1:0] MAX_EXT  = CMP_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sat;
  logic               lost;

  logic [ACC_W-1:0]   corr;
  logic               bin_sat;

  assign bin_sat = (CMP_W'(bin) > MAX_EXT);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (acc[4*g +: 4]),
      .dout (corr[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      lost  <= 1'b0;
      bcd   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            acc   <= '0;
            cnt   <= '0;
            sat   <= bin_sat;
            lost  <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // A carry out of the top digit can only happen when sat is already
          // set; folding it in keeps the output saturated in any case.
          lost  <= lost | corr[ACC_W-1];
          acc   <= {corr[ACC_W-2:0], shreg[BIN_W-1]};
          shreg <= shreg << 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end
        end

        DONE: begin
          bcd   <= (sat | lost) ? {DIGITS{BCD_NINE}} : acc;
          ovf   <= sat | lost;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_bin2bcd.sv
// ============================================================================
// tb_score_bin2bcd
// Self-checking bench for score_bin2bcd against an arithmetic decimal model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_score_bin2bcd;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bin   = 8'd0;
  logic [7:0] bcd;
  logic       done;
  logic       busy;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  logic [7:0] held_bcd = 8'h00;
  logic       held_ovf = 1'b0;

  score_bin2bcd #(
    .BIN_W  (8),
    .DIGITS (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: two digits from plain division, saturated above 99.
  function automatic logic [7:0] ref_bcd(input int v);
    if (v > 99) return 8'h99;
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // One full conversion; optionally pulses a stray start during the busy window.
  task automatic convert(input string tag, input logic [7:0] v, input int glitch);
    int         lat;
    logic       stable;
    logic [7:0] exp_b;
    logic       exp_o;
    exp_b = ref_bcd(int'(v));
    exp_o = (int'(v) > 99);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 8'($urandom);
    check({tag, "/busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "/done_low_after_start"}, 32'(done), 32'd0);
    lat    = 0;
    stable = 1'b1;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (n == glitch) begin
        start = 1'b1;
        bin   = 8'd55;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) lat = n;
      else if (busy !== 1'b1 || bcd !== held_bcd || ovf !== held_ovf) stable = 1'b0;
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'd9);
    check({tag, "/hold_while_busy"}, 32'(stable), 32'd1);
    check({tag, "/bcd"}, 32'(bcd), 32'(exp_b));
    check({tag, "/ovf"}, 32'(ovf), 32'(exp_o));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    held_bcd = exp_b;
    held_ovf = exp_o;
  endtask

  // Nothing may start or complete while start stays low.
  task automatic idle_watch(input string tag, input int cycles);
    logic quiet;
    quiet = 1'b1;
    start = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || bcd !== held_bcd || ovf !== held_ovf) quiet = 1'b0;
    end
    check({tag, "/quiet"}, 32'(quiet), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("reset/bcd", 32'(bcd), 32'h00);
    check("reset/done", 32'(done), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    convert("c47", 8'd47, 0);

    convert("c0", 8'd0, 0);
    convert("c99", 8'd99, 0);

    convert("c200", 8'd200, 0);
    convert("c9", 8'd9, 0);

    convert("c12_stray_start", 8'd12, 3);
    idle_watch("c12_no_queue", 12);

    // Abort a conversion of 88 part-way through SHIFT.
    convert("c47_again", 8'd47, 0);
    start = 1'b1;
    bin   = 8'd88;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort/bcd", 32'(bcd), 32'h00);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/ovf", 32'(ovf), 32'd0);
    held_bcd = 8'h00;
    held_ovf = 1'b0;
    idle_watch("abort", 12);

    // Reset takes priority over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    bin   = 8'd77;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_vs_start/busy", 32'(busy), 32'd0);
    idle_watch("rst_vs_start", 12);

    convert("c88", 8'd88, 0);

    for (int v = 0; v < 256; v++) begin
      convert($sformatf("sweep%0d", v), 8'(v), 0);
    end

    for (int k = 0; k < 30; k++) begin
      convert($sformatf("rand%0d", k), 8'($urandom), int'($urandom_range(0, 9)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
